// File: rtl/gmii_tx_arbiter.sv
// Two-source GMII transmit arbiter: round-robin at frame boundaries, minimum IPG,
// and TX_ER marking of source underruns and bytes past MAX_FRAME.
module gmii_tx_arbiter #(
  parameter int IPG_CYCLES = 12,
  parameter int MAX_FRAME  = 1522
) (
  input  logic       Clk,
  input  logic       mr_main_reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  input  logic       valid_a,
  input  logic       valid_b,
  input  logic       last_a,
  input  logic       last_b,
  output logic       ready_a,
  output logic       ready_b,
  output logic [7:0] TXD,
  output logic       TX_EN,
  output logic       TX_ER,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int CNT_W = $clog2(MAX_FRAME + 1);
  localparam int IPG_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XMIT,
    ST_IPG
  } state_t;

  state_t             state_reg, state_next;
  logic [1:0]         grant_reg, grant_next;
  logic               rr_b_reg, rr_b_next;       // 1: B wins the next tie
  logic [CNT_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic               started_reg, started_next; // first byte of frame accepted
  logic [IPG_W-1:0]   ipg_cnt_reg, ipg_cnt_next;
  logic [7:0]         txd_reg, txd_next;
  logic               tx_en_reg, tx_en_next;
  logic               tx_er_reg, tx_er_next;

  logic [1:0] src_valid;
  logic [1:0] src_last;
  logic [1:0] ready_vec;
  logic       accept;
  logic       sel_last;
  logic [7:0] sel_data;
  logic       pick_b;

  assign src_valid = {valid_b, valid_a};
  assign src_last  = {last_b, last_a};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = grant_reg[gi] & (state_reg == ST_XMIT);
    end
  endgenerate

  assign ready_a  = ready_vec[0];
  assign ready_b  = ready_vec[1];
  assign accept   = |(ready_vec & src_valid);
  assign sel_last = |(ready_vec & src_last);
  assign sel_data = grant_reg[1] ? data_b : data_a;
  assign pick_b   = req_b & (~req_a | rr_b_reg);

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_b_next     = rr_b_reg;
    byte_cnt_next = byte_cnt_reg;
    started_next  = started_reg;
    ipg_cnt_next  = ipg_cnt_reg;
    txd_next      = 8'h00;
    tx_en_next    = 1'b0;
    tx_er_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_a | req_b) begin
          grant_next    = pick_b ? 2'b10 : 2'b01;
          rr_b_next     = ~pick_b;
          byte_cnt_next = '0;
          started_next  = 1'b0;
          state_next    = ST_XMIT;
        end
      end
      ST_XMIT: begin
        if (accept) begin
          txd_next     = sel_data;
          tx_en_next   = 1'b1;
          tx_er_next   = (byte_cnt_reg >= CNT_W'(MAX_FRAME));
          started_next = 1'b1;
          if (byte_cnt_reg != '1) begin
            byte_cnt_next = byte_cnt_reg + CNT_W'(1);
          end
          if (sel_last) begin
            grant_next   = 2'b00;
            ipg_cnt_next = IPG_W'(IPG_CYCLES - 1);
            state_next   = ST_IPG;
          end
        end else if (started_reg) begin
          // Underrun inside a frame: keep TX_EN up and poison the frame.
          tx_en_next = 1'b1;
          tx_er_next = 1'b1;
        end
      end
      ST_IPG: begin
        if (ipg_cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          ipg_cnt_next = ipg_cnt_reg - IPG_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = 2'b00;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (mr_main_reset) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= 2'b00;
      rr_b_reg     <= 1'b0;
      byte_cnt_reg <= '0;
      started_reg  <= 1'b0;
      ipg_cnt_reg  <= '0;
      txd_reg      <= 8'h00;
      tx_en_reg    <= 1'b0;
      tx_er_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_b_reg     <= rr_b_next;
      byte_cnt_reg <= byte_cnt_next;
      started_reg  <= started_next;
      ipg_cnt_reg  <= ipg_cnt_next;
      txd_reg      <= txd_next;
      tx_en_reg    <= tx_en_next;
      tx_er_reg    <= tx_er_next;
    end
  end

  assign TXD   = txd_reg;
  assign TX_EN = tx_en_reg;
  assign TX_ER = tx_er_reg;
  assign grant = grant_reg;
  assign busy  = (state_reg != ST_IDLE);

endmodule
